memory_arbiter: RTL and testbench

// - Shares the single memory port between instruction fetch (word reads only) and load/store data.
// - Sits between the core front-end/LSU and the memory block.
// - Sequences each access: grant, memory access for MEM_LATENCY cycles, one-cycle response.
// - Data wins ties; a starvation limit bounds how long fetch waits.

---
 rtl/memory_arbiter_pkg.sv | 47 ++++
 rtl/memory_arbiter_if.sv | 46 ++++
 rtl/memory_arbiter_starve_picker.sv | 48 ++++
 rtl/memory_arbiter.sv | 176 +++++++++++++++++
 tb/tb_memory_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory arbiter: memory mode codes, FSM states, owner tags,
// the registered access payload and the starve-counter saturating increment.
package memory_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [2:0] {
        LOAD_BYTE          = 3'd0,
        LOAD_HALF          = 3'd1,
        LOAD_WORD          = 3'd2,
        LOAD_BYTE_UNSIGNED = 3'd3,
        LOAD_HALF_UNSIGNED = 3'd4,
        STORE_BYTE         = 3'd5,
        STORE_HALF         = 3'd6,
        STORE_WORD         = 3'd7
    } mem_mode_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    typedef struct packed {
        logic              write;
        logic [2:0]        mode;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } payload_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        if (v >= lim) begin
            return lim;
        end else begin
            return v + 4'd1;
        end
    endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals of the arbiter.
// slave = arbiter view, master = environment (core front-end, LSU and memory).
interface memory_arbiter_if;
    logic        i_FetchReq;
    logic [31:0] i_FetchAddr;
    logic        o_FetchGnt;
    logic        o_FetchRspValid;
    logic [31:0] o_FetchData;
    logic        o_FetchFault;
    logic        i_DataReq;
    logic        i_DataWrite;
    logic [31:0] i_DataAddr;
    logic [31:0] i_DataWdata;
    logic [2:0]  i_DataMode;
    logic        o_DataGnt;
    logic        o_DataRspValid;
    logic [31:0] o_DataRdata;
    logic        o_DataMisaligned;
    logic        o_DataBadMode;
    logic        o_MemWriteEnable;
    logic        o_MemReadEnable;
    logic [31:0] o_MemAddress;
    logic [31:0] o_MemDataIn;
    logic [2:0]  o_MemMode;
    logic [31:0] i_MemDataOut;
    logic        i_MemMisaligned;
    logic        i_MemBadMode;

    modport slave (
        input  i_FetchReq, i_FetchAddr,
        output o_FetchGnt, o_FetchRspValid, o_FetchData, o_FetchFault,
        input  i_DataReq, i_DataWrite, i_DataAddr, i_DataWdata, i_DataMode,
        output o_DataGnt, o_DataRspValid, o_DataRdata, o_DataMisaligned, o_DataBadMode,
        output o_MemWriteEnable, o_MemReadEnable, o_MemAddress, o_MemDataIn, o_MemMode,
        input  i_MemDataOut, i_MemMisaligned, i_MemBadMode
    );

    modport master (
        output i_FetchReq, i_FetchAddr,
        input  o_FetchGnt, o_FetchRspValid, o_FetchData, o_FetchFault,
        output i_DataReq, i_DataWrite, i_DataAddr, i_DataWdata, i_DataMode,
        input  o_DataGnt, o_DataRspValid, o_DataRdata, o_DataMisaligned, o_DataBadMode,
        input  o_MemWriteEnable, o_MemReadEnable, o_MemAddress, o_MemDataIn, o_MemMode,
        output i_MemDataOut, i_MemMisaligned, i_MemBadMode
    );
endinterface

// File: rtl/memory_arbiter_starve_picker.sv
// Winner select between fetch and data: data wins ties until fetch has been
// passed over STARVE_LIMIT consecutive times.
module arb_starve_picker
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic fetch_req_i,
    input  logic data_req_i,
    input  logic grant_ok_i,
    output logic fetch_win_o,
    output logic data_win_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign fetch_win_o = grant_ok_i & fetch_req_i & (~data_req_i | (cnt_q == LIMIT));
    assign data_win_o  = grant_ok_i & data_req_i & ~fetch_win_o;

    // Count data grants that bypassed a waiting fetch; any other grant clears it.
    always_comb begin
        cnt_d = cnt_q;
        if (fetch_win_o | data_win_o) begin
            if (fetch_win_o | ~fetch_req_i) begin
                cnt_d = '0;
            end else begin
                cnt_d = sat_inc(cnt_q, LIMIT);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Starve counter register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one memory port between instruction fetch and load/store data:
// grant, MEM_LATENCY access cycles, then a single-cycle response.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            i_Clock,
    input  logic            i_Reset_n,
    memory_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LATENCY - 1);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  lat_q, lat_d;
    owner_t            owner_q, owner_d;
    payload_t          pay_q, pay_d;
    payload_t          win_pay_s;
    logic              mem_we_q, mem_we_d, mem_re_q, mem_re_d;
    logic [31:0]       mem_addr_q, mem_addr_d, mem_din_q, mem_din_d;
    logic [2:0]        mem_mode_q, mem_mode_d;
    logic              f_valid_q, f_valid_d, f_fault_q, f_fault_d;
    logic [31:0]       f_data_q, f_data_d;
    logic              d_valid_q, d_valid_d, d_mis_q, d_mis_d, d_bad_q, d_bad_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic              grant_ok_s, fetch_win_s, data_win_s;

    // Reset also masks the combinational grants so every output is 0 while held.
    assign grant_ok_s = i_Reset_n & ((state_q == IDLE) | (state_q == RESPOND));

    arb_starve_picker #(.STARVE_LIMIT(STARVE_LIMIT)) u_picker (
        .clk_i       (i_Clock),
        .rst_n_i     (i_Reset_n),
        .fetch_req_i (bus.i_FetchReq),
        .data_req_i  (bus.i_DataReq),
        .grant_ok_i  (grant_ok_s),
        .fetch_win_o (fetch_win_s),
        .data_win_o  (data_win_s)
    );

    assign bus.o_FetchGnt = fetch_win_s;
    assign bus.o_DataGnt  = data_win_s;

    // Payload of the winner; a fetch is always a plain word read.
    always_comb begin
        if (fetch_win_s) begin
            win_pay_s.write = 1'b0;
            win_pay_s.mode  = LOAD_WORD;
            win_pay_s.addr  = bus.i_FetchAddr;
            win_pay_s.wdata = 32'd0;
        end else begin
            win_pay_s.write = bus.i_DataWrite;
            win_pay_s.mode  = bus.i_DataMode;
            win_pay_s.addr  = bus.i_DataAddr;
            win_pay_s.wdata = bus.i_DataWdata;
        end
    end

    // Next state, memory-side drive and response capture.
    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        owner_d    = owner_q;
        pay_d      = pay_q;
        mem_we_d   = 1'b0;
        mem_re_d   = 1'b0;
        mem_addr_d = 32'd0;
        mem_din_d  = 32'd0;
        mem_mode_d = 3'd0;
        f_valid_d  = 1'b0;
        f_data_d   = f_data_q;
        f_fault_d  = f_fault_q;
        d_valid_d  = 1'b0;
        d_rdata_d  = d_rdata_q;
        d_mis_d    = d_mis_q;
        d_bad_d    = d_bad_q;
        case (state_q)
            IDLE, RESPOND: begin
                if (fetch_win_s | data_win_s) begin
                    state_d    = ACCESS;
                    lat_d      = '0;
                    owner_d    = fetch_win_s ? OWN_FETCH : OWN_DATA;
                    pay_d      = win_pay_s;
                    mem_we_d   = win_pay_s.write;
                    mem_re_d   = ~win_pay_s.write;
                    mem_addr_d = win_pay_s.addr;
                    mem_din_d  = win_pay_s.wdata;
                    mem_mode_d = win_pay_s.mode;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (lat_q == LAT_LAST) begin
                    state_d = RESPOND;
                    lat_d   = '0;
                    if (owner_q == OWN_FETCH) begin
                        f_valid_d = 1'b1;
                        f_data_d  = bus.i_MemDataOut;
                        f_fault_d = bus.i_MemMisaligned | bus.i_MemBadMode;
                    end else begin
                        d_valid_d = 1'b1;
                        d_rdata_d = pay_q.write ? 32'd0 : bus.i_MemDataOut;
                        d_mis_d   = bus.i_MemMisaligned;
                        d_bad_d   = bus.i_MemBadMode;
                    end
                end else begin
                    // Stores write only in the first cycle; reads stay enabled throughout.
                    lat_d      = lat_q + 4'd1;
                    mem_re_d   = ~pay_q.write;
                    mem_addr_d = pay_q.addr;
                    mem_din_d  = pay_q.wdata;
                    mem_mode_d = pay_q.mode;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, payload, memory-drive and response registers.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q    <= IDLE;
            lat_q      <= '0;
            owner_q    <= OWN_FETCH;
            pay_q      <= '0;
            mem_we_q   <= 1'b0;
            mem_re_q   <= 1'b0;
            mem_addr_q <= 32'd0;
            mem_din_q  <= 32'd0;
            mem_mode_q <= 3'd0;
            f_valid_q  <= 1'b0;
            f_data_q   <= 32'd0;
            f_fault_q  <= 1'b0;
            d_valid_q  <= 1'b0;
            d_rdata_q  <= 32'd0;
            d_mis_q    <= 1'b0;
            d_bad_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            owner_q    <= owner_d;
            pay_q      <= pay_d;
            mem_we_q   <= mem_we_d;
            mem_re_q   <= mem_re_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_mode_q <= mem_mode_d;
            f_valid_q  <= f_valid_d;
            f_data_q   <= f_data_d;
            f_fault_q  <= f_fault_d;
            d_valid_q  <= d_valid_d;
            d_rdata_q  <= d_rdata_d;
            d_mis_q    <= d_mis_d;
            d_bad_q    <= d_bad_d;
        end
    end

    assign bus.o_FetchRspValid  = f_valid_q;
    assign bus.o_FetchData      = f_data_q;
    assign bus.o_FetchFault     = f_fault_q;
    assign bus.o_DataRspValid   = d_valid_q;
    assign bus.o_DataRdata      = d_rdata_q;
    assign bus.o_DataMisaligned = d_mis_q;
    assign bus.o_DataBadMode    = d_bad_q;
    assign bus.o_MemWriteEnable = mem_we_q;
    assign bus.o_MemReadEnable  = mem_re_q;
    assign bus.o_MemAddress     = mem_addr_q;
    assign bus.o_MemDataIn      = mem_din_q;
    assign bus.o_MemMode        = mem_mode_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: a latency-1 instance carries most traffic,
// a latency-3 instance covers the multi-cycle store.
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    typedef struct {
        logic        own;
        logic        write;
        logic [31:0] addr;
        logic [2:0]  mode;
        logic [31:0] wdata;
        logic [31:0] data;
        logic        f1;
        logic        f2;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_bad = 1'b0;
    int   cyc = 0;
    int   n_err = 0;
    int   n_chk = 0;
    exp_t sbq[$];
    exp_t mon_e;
    logic glog[$];
    int   gcyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    memory_arbiter_if bus ();
    memory_arbiter_if bus3 ();

    memory_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) dut (
        .i_Clock(clk), .i_Reset_n(rst_n), .bus(bus));
    memory_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
        .i_Clock(clk), .i_Reset_n(rst_n), .bus(bus3));

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'h3;
    endfunction

    function automatic logic mis_of(input logic [2:0] m, input logic [1:0] a);
        case (m)
            LOAD_HALF, LOAD_HALF_UNSIGNED, STORE_HALF: return a[0];
            LOAD_WORD, STORE_WORD:                     return |a;
            default:                                   return 1'b0;
        endcase
    endfunction

    always_comb begin
        bus.i_MemDataOut    = bus.o_MemReadEnable ? mem_word(bus.o_MemAddress) : 32'd0;
        bus.i_MemMisaligned = mis_of(bus.o_MemMode, bus.o_MemAddress[1:0]);
        bus.i_MemBadMode    = mem_bad;
        bus3.i_MemDataOut    = bus3.o_MemReadEnable ? mem_word(bus3.o_MemAddress) : 32'd0;
        bus3.i_MemMisaligned = mis_of(bus3.o_MemMode, bus3.o_MemAddress[1:0]);
        bus3.i_MemBadMode    = 1'b0;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue n requests on one channel, holding the request across grants.
    task automatic req_seq(input bit dsel, input int n, input logic wr,
                           input logic [31:0] addr, input logic [2:0] mode,
                           output int first_wait);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            if (dsel) begin
                bus.i_DataReq   = 1'b1;
                bus.i_DataWrite = wr;
                bus.i_DataAddr  = addr + 32'(4 * i);
                bus.i_DataWdata = (addr + 32'(4 * i)) ^ 32'hDEAD0000;
                bus.i_DataMode  = mode;
            end else begin
                bus.i_FetchReq  = 1'b1;
                bus.i_FetchAddr = addr + 32'(4 * i);
            end
            @(negedge clk);
            while (!(dsel ? bus.o_DataGnt : bus.o_FetchGnt) && w < 100) begin
                w++;
                @(negedge clk);
            end
            if (w >= 100) chk_eq("gnt_timeout", dsel ? bus.o_DataGnt : bus.o_FetchGnt, 32'd1);
            if (i == 0) first_wait = w;
            @(posedge clk);
            #1;
        end
        if (dsel) bus.i_DataReq = 1'b0;
        else bus.i_FetchReq = 1'b0;
    endtask

    // Monitor for the latency-1 instance: pop on response, check memory drive, push on grant.
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
        end else begin
            chk_eq("dual_gnt", {31'd0, bus.o_FetchGnt & bus.o_DataGnt}, 32'd0);
            if (bus.o_FetchRspValid || bus.o_DataRspValid) begin
                chk_eq("rsp_pending", {31'd0, sbq.size() > 0}, 32'd1);
                if (sbq.size() > 0) begin
                    mon_e = sbq.pop_front();
                    chk_eq("rsp_owner", {31'd0, bus.o_DataRspValid}, {31'd0, mon_e.own});
                    chk_eq("rsp_cycle", cyc, mon_e.cyc);
                    if (!mon_e.own) begin
                        chk_eq("fetch_data", bus.o_FetchData, mon_e.data);
                        chk_eq("fetch_fault", {31'd0, bus.o_FetchFault}, {31'd0, mon_e.f1});
                    end else begin
                        chk_eq("data_rdata", bus.o_DataRdata, mon_e.data);
                        chk_eq("data_mis", {31'd0, bus.o_DataMisaligned}, {31'd0, mon_e.f1});
                        chk_eq("data_bad", {31'd0, bus.o_DataBadMode}, {31'd0, mon_e.f2});
                    end
                end
            end
            if (bus.o_MemReadEnable || bus.o_MemWriteEnable) begin
                chk_eq("mem_busy_owner", {31'd0, sbq.size() > 0}, 32'd1);
                if (sbq.size() > 0) begin
                    chk_eq("mem_addr", bus.o_MemAddress, sbq[0].addr);
                    chk_eq("mem_mode", {29'd0, bus.o_MemMode}, {29'd0, sbq[0].mode});
                    chk_eq("mem_we", {31'd0, bus.o_MemWriteEnable}, {31'd0, sbq[0].write});
                    chk_eq("mem_din", bus.o_MemDataIn, sbq[0].wdata);
                end
            end
            if (bus.o_FetchGnt) begin
                mon_e.own = 1'b0; mon_e.write = 1'b0; mon_e.addr = bus.i_FetchAddr;
                mon_e.mode = LOAD_WORD; mon_e.wdata = 32'd0;
                mon_e.data = mem_word(bus.i_FetchAddr);
                mon_e.f1 = mis_of(LOAD_WORD, bus.i_FetchAddr[1:0]) | mem_bad;
                mon_e.f2 = 1'b0; mon_e.cyc = cyc + 2;
                sbq.push_back(mon_e);
                glog.push_back(1'b0);
            end
            if (bus.o_DataGnt) begin
                mon_e.own = 1'b1; mon_e.write = bus.i_DataWrite; mon_e.addr = bus.i_DataAddr;
                mon_e.mode = bus.i_DataMode; mon_e.wdata = bus.i_DataWdata;
                mon_e.data = bus.i_DataWrite ? 32'd0 : mem_word(bus.i_DataAddr);
                mon_e.f1 = mis_of(bus.i_DataMode, bus.i_DataAddr[1:0]);
                mon_e.f2 = mem_bad; mon_e.cyc = cyc + 2;
                sbq.push_back(mon_e);
                glog.push_back(1'b1);
                gcyc.push_back(cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fw;
        int idx;
        int t3;
        int we_cnt;
        int rsp3_cyc;
        logic [31:0] rdata3;
        bus.i_FetchReq = 1'b0; bus.i_FetchAddr = 32'd0;
        bus.i_DataReq = 1'b0; bus.i_DataWrite = 1'b0; bus.i_DataAddr = 32'd0;
        bus.i_DataWdata = 32'd0; bus.i_DataMode = 3'd0;
        bus3.i_FetchReq = 1'b0; bus3.i_FetchAddr = 32'd0;
        bus3.i_DataReq = 1'b0; bus3.i_DataWrite = 1'b0; bus3.i_DataAddr = 32'd0;
        bus3.i_DataWdata = 32'd0; bus3.i_DataMode = 3'd0;

        idle(3);
        chk_eq("reset_outputs", {31'd0, |{bus.o_FetchRspValid, bus.o_FetchData, bus.o_FetchFault,
               bus.o_DataRspValid, bus.o_DataRdata, bus.o_DataMisaligned, bus.o_DataBadMode,
               bus.o_MemWriteEnable, bus.o_MemReadEnable, bus.o_MemAddress, bus.o_MemDataIn,
               bus.o_MemMode}}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Single fetch: granted immediately from IDLE, response two cycles later.
        req_seq(1'b0, 1, 1'b0, 32'h00000010, LOAD_WORD, fw);
        chk_eq("fetch_first_wait", fw, 32'd0);
        idle(3);

        // Both pending: four data grants, then the starved fetch.
        glog.delete();
        fork
            req_seq(1'b1, 5, 1'b0, 32'h00000200, LOAD_WORD, fw);
            req_seq(1'b0, 1, 1'b0, 32'h00000040, LOAD_WORD, fw);
            begin
                int w = 0;
                @(negedge clk);
                while (!bus.o_FetchGnt && w < 100) begin w++; @(negedge clk); end
                chk_eq("starve_cnt_at_fgnt", {28'd0, dut.u_picker.cnt_q}, 32'd4);
                @(posedge clk); #1;
                chk_eq("starve_cnt_after_fgnt", {28'd0, dut.u_picker.cnt_q}, 32'd0);
            end
        join
        idle(3);
        idx = -1;
        for (int i = glog.size() - 1; i >= 0; i--) if (!glog[i]) idx = i;
        chk_eq("starve_fetch_idx", idx, 32'd4);
        chk_eq("starve_gnt_total", glog.size(), 32'd6);

        // Alignment and mode flags.
        req_seq(1'b1, 1, 1'b0, 32'h00000101, LOAD_WORD, fw);
        idle(2);
        req_seq(1'b0, 1, 1'b0, 32'h00000102, LOAD_WORD, fw);
        idle(2);
        mem_bad = 1'b1;
        req_seq(1'b1, 1, 1'b0, 32'h00000104, LOAD_HALF, fw);
        idle(3);
        mem_bad = 1'b0;
        req_seq(1'b1, 1, 1'b1, 32'h00000300, STORE_WORD, fw);
        idle(2);
        req_seq(1'b1, 1, 1'b1, 32'h00000301, STORE_HALF, fw);
        idle(2);
        req_seq(1'b1, 1, 1'b0, 32'h00000103, LOAD_BYTE_UNSIGNED, fw);
        idle(3);

        // Back-to-back loads: a grant every MEM_LATENCY+1 cycles.
        gcyc.delete();
        req_seq(1'b1, 4, 1'b0, 32'h00000400, LOAD_WORD, fw);
        idle(3);
        chk_eq("b2b_gnt_count", gcyc.size(), 32'd4);
        for (int i = 1; i < gcyc.size(); i++) chk_eq("b2b_gnt_spacing", gcyc[i] - gcyc[i-1], 32'd2);

        // Reset in the middle of an access drops it without a response.
        bus.i_DataReq = 1'b1; bus.i_DataWrite = 1'b0; bus.i_DataAddr = 32'h00000500;
        bus.i_DataMode = LOAD_WORD;
        @(negedge clk);
        chk_eq("pre_reset_gnt", {31'd0, bus.o_DataGnt}, 32'd1);
        @(posedge clk); #1;
        chk_eq("pre_reset_access", {31'd0, bus.o_MemReadEnable}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_eq("midreset_outputs", {31'd0, |{bus.o_DataGnt, bus.o_FetchGnt, bus.o_DataRspValid,
               bus.o_DataRdata, bus.o_MemReadEnable, bus.o_MemAddress, bus.o_MemMode}}, 32'd0);
        bus.i_DataReq = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(4);
        req_seq(1'b0, 1, 1'b0, 32'h00000060, LOAD_WORD, fw);
        chk_eq("post_reset_first_wait", fw, 32'd0);
        idle(3);
        chk_eq("sb_drained", sbq.size(), 32'd0);

        // Latency-3 store: one write strobe, response at T+4 with zero read data.
        bus3.i_DataReq = 1'b1; bus3.i_DataWrite = 1'b1; bus3.i_DataAddr = 32'h00000102;
        bus3.i_DataWdata = 32'h000000AB; bus3.i_DataMode = STORE_BYTE;
        @(negedge clk);
        chk_eq("l3_gnt", {31'd0, bus3.o_DataGnt}, 32'd1);
        t3 = cyc;
        @(posedge clk); #1;
        bus3.i_DataReq = 1'b0;
        we_cnt = 0; rsp3_cyc = -1; rdata3 = 32'hFFFFFFFF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus3.o_MemWriteEnable) begin
                we_cnt++;
                chk_eq("l3_mem_din", bus3.o_MemDataIn, 32'h000000AB);
            end
            if (bus3.o_DataRspValid) begin
                rsp3_cyc = cyc;
                rdata3 = bus3.o_DataRdata;
                chk_eq("l3_mis", {31'd0, bus3.o_DataMisaligned}, 32'd0);
            end
        end
        chk_eq("l3_we_cycles", we_cnt, 32'd1);
        chk_eq("l3_rsp_cycle", rsp3_cyc, t3 + 4);
        chk_eq("l3_rdata", rdata3, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
